// File: rtl/hicore_tcm_icb_arbiter_pkg.sv
// Shared ICB definitions for the TCM arbiter: field widths and master ids.
package HiCore_icb_pkg;

    localparam int ICB_AW = 32;
    localparam int ICB_DW = 32;
    localparam int ID_W   = 1;

    typedef logic [ID_W-1:0] mid_t;

    localparam mid_t ID_M0 = 1'b0;
    localparam mid_t ID_M1 = 1'b1;

    function automatic mid_t other_id(input mid_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/hicore_tcm_icb_arbiter_id_fifo.sv
// In-order master-id FIFO for the TCM arbiter.
// Remembers which master issued each outstanding command.
module hicore_arb_id_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign dout    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/hicore_tcm_icb_arbiter.sv
// Two-master to one-slave ICB arbiter in front of the TCM controller.
// Define HICORE_TCM_ARB_RR_EN for round-robin arbitration (default: m1 > m0).
module hicore_tcm_icb_arbiter
    import HiCore_icb_pkg::*;
#(
    parameter int AW       = ICB_AW,
    parameter int DW       = ICB_DW,
    parameter int OUTSTAND = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      m0_icb_cmd_valid,
    output logic                      m0_icb_cmd_ready,
    input  logic                      m0_icb_cmd_read,
    input  logic [AW-1:0]             m0_icb_cmd_addr,
    input  logic [DW-1:0]             m0_icb_cmd_wdata,
    input  logic [DW/8-1:0]           m0_icb_cmd_wmask,
    output logic                      m0_icb_rsp_valid,
    input  logic                      m0_icb_rsp_ready,
    output logic                      m0_icb_rsp_err,
    output logic [DW-1:0]             m0_icb_rsp_rdata,

    input  logic                      m1_icb_cmd_valid,
    output logic                      m1_icb_cmd_ready,
    input  logic                      m1_icb_cmd_read,
    input  logic [AW-1:0]             m1_icb_cmd_addr,
    input  logic [DW-1:0]             m1_icb_cmd_wdata,
    input  logic [DW/8-1:0]           m1_icb_cmd_wmask,
    output logic                      m1_icb_rsp_valid,
    input  logic                      m1_icb_rsp_ready,
    output logic                      m1_icb_rsp_err,
    output logic [DW-1:0]             m1_icb_rsp_rdata,

    output logic                      s_icb_cmd_valid,
    input  logic                      s_icb_cmd_ready,
    output logic                      s_icb_cmd_read,
    output logic [AW-1:0]             s_icb_cmd_addr,
    output logic [DW-1:0]             s_icb_cmd_wdata,
    output logic [DW/8-1:0]           s_icb_cmd_wmask,
    input  logic                      s_icb_rsp_valid,
    output logic                      s_icb_rsp_ready,
    input  logic                      s_icb_rsp_err,
    input  logic [DW-1:0]             s_icb_rsp_rdata,

    output logic [$clog2(OUTSTAND):0] outstanding_cnt
);

    mid_t grant;
    mid_t tie_win;
    mid_t lock_id_q;
    mid_t head_id;
    logic lock_q;
    logic grant_valid;
    logic cmd_hs;
    logic fifo_full;
    logic fifo_empty;
    logic rsp_pop;
    logic to_m0;
    logic to_m1;

`ifdef HICORE_TCM_ARB_RR_EN
    mid_t last_q;

    assign tie_win = other_id(last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      last_q <= ID_M0;
        else if (cmd_hs) last_q <= grant;
    end
`else
    assign tie_win = ID_M1;
`endif

    // A stalled grant is held until it completes its handshake
    always_comb begin
        grant = ID_M0;
        if (lock_q)
            grant = lock_id_q;
        else if (m0_icb_cmd_valid && m1_icb_cmd_valid)
            grant = tie_win;
        else if (m1_icb_cmd_valid)
            grant = ID_M1;
    end

    assign grant_valid = (grant == ID_M1) ? m1_icb_cmd_valid
                                          : m0_icb_cmd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q    <= 1'b0;
            lock_id_q <= ID_M0;
        end else begin
            lock_q    <= grant_valid & ~cmd_hs;
            lock_id_q <= grant;
        end
    end

    assign s_icb_cmd_valid  = grant_valid & ~fifo_full;
    assign cmd_hs           = s_icb_cmd_valid & s_icb_cmd_ready;
    assign m0_icb_cmd_ready = (grant == ID_M0) & s_icb_cmd_ready & ~fifo_full;
    assign m1_icb_cmd_ready = (grant == ID_M1) & s_icb_cmd_ready & ~fifo_full;

    always_comb begin
        s_icb_cmd_read  = m0_icb_cmd_read;
        s_icb_cmd_addr  = m0_icb_cmd_addr;
        s_icb_cmd_wdata = m0_icb_cmd_wdata;
        s_icb_cmd_wmask = m0_icb_cmd_wmask;
        if (grant == ID_M1) begin
            s_icb_cmd_read  = m1_icb_cmd_read;
            s_icb_cmd_addr  = m1_icb_cmd_addr;
            s_icb_cmd_wdata = m1_icb_cmd_wdata;
            s_icb_cmd_wmask = m1_icb_cmd_wmask;
        end
    end

    hicore_arb_id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (OUTSTAND)
    ) u_id_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_hs),
        .din   (grant),
        .pop   (rsp_pop),
        .dout  (head_id),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (outstanding_cnt)
    );

    // Responses with nothing outstanding are held off, never forwarded
    assign to_m0 = ~fifo_empty & (head_id == ID_M0);
    assign to_m1 = ~fifo_empty & (head_id == ID_M1);

    assign s_icb_rsp_ready  = (to_m0 & m0_icb_rsp_ready)
                            | (to_m1 & m1_icb_rsp_ready);
    assign rsp_pop          = s_icb_rsp_valid & s_icb_rsp_ready;

    assign m0_icb_rsp_valid = to_m0 & s_icb_rsp_valid;
    assign m0_icb_rsp_err   = to_m0 & s_icb_rsp_err;
    assign m0_icb_rsp_rdata = to_m0 ? s_icb_rsp_rdata : '0;
    assign m1_icb_rsp_valid = to_m1 & s_icb_rsp_valid;
    assign m1_icb_rsp_err   = to_m1 & s_icb_rsp_err;
    assign m1_icb_rsp_rdata = to_m1 ? s_icb_rsp_rdata : '0;

endmodule

// File: tb/tb_hicore_tcm_icb_arbiter.sv
// Directed self-checking bench for hicore_tcm_icb_arbiter.
// Round-robin expectations apply when HICORE_TCM_ARB_RR_EN is defined.
module tb_hicore_tcm_icb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cmd_valid, m0_cmd_ready, m0_cmd_read;
    logic [31:0] m0_cmd_addr, m0_cmd_wdata;
    logic [3:0]  m0_cmd_wmask;
    logic        m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
    logic [31:0] m0_rsp_rdata;
    logic        m1_cmd_valid, m1_cmd_ready, m1_cmd_read;
    logic [31:0] m1_cmd_addr, m1_cmd_wdata;
    logic [3:0]  m1_cmd_wmask;
    logic        m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
    logic [31:0] m1_rsp_rdata;
    logic        s_cmd_valid, s_cmd_ready, s_cmd_read;
    logic [31:0] s_cmd_addr, s_cmd_wdata;
    logic [3:0]  s_cmd_wmask;
    logic        s_rsp_valid, s_rsp_ready, s_rsp_err;
    logic [31:0] s_rsp_rdata;
    logic [2:0]  cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hicore_tcm_icb_arbiter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .m0_icb_cmd_valid (m0_cmd_valid),
        .m0_icb_cmd_ready (m0_cmd_ready),
        .m0_icb_cmd_read  (m0_cmd_read),
        .m0_icb_cmd_addr  (m0_cmd_addr),
        .m0_icb_cmd_wdata (m0_cmd_wdata),
        .m0_icb_cmd_wmask (m0_cmd_wmask),
        .m0_icb_rsp_valid (m0_rsp_valid),
        .m0_icb_rsp_ready (m0_rsp_ready),
        .m0_icb_rsp_err   (m0_rsp_err),
        .m0_icb_rsp_rdata (m0_rsp_rdata),
        .m1_icb_cmd_valid (m1_cmd_valid),
        .m1_icb_cmd_ready (m1_cmd_ready),
        .m1_icb_cmd_read  (m1_cmd_read),
        .m1_icb_cmd_addr  (m1_cmd_addr),
        .m1_icb_cmd_wdata (m1_cmd_wdata),
        .m1_icb_cmd_wmask (m1_cmd_wmask),
        .m1_icb_rsp_valid (m1_rsp_valid),
        .m1_icb_rsp_ready (m1_rsp_ready),
        .m1_icb_rsp_err   (m1_rsp_err),
        .m1_icb_rsp_rdata (m1_rsp_rdata),
        .s_icb_cmd_valid  (s_cmd_valid),
        .s_icb_cmd_ready  (s_cmd_ready),
        .s_icb_cmd_read   (s_cmd_read),
        .s_icb_cmd_addr   (s_cmd_addr),
        .s_icb_cmd_wdata  (s_cmd_wdata),
        .s_icb_cmd_wmask  (s_cmd_wmask),
        .s_icb_rsp_valid  (s_rsp_valid),
        .s_icb_rsp_ready  (s_rsp_ready),
        .s_icb_rsp_err    (s_rsp_err),
        .s_icb_rsp_rdata  (s_rsp_rdata),
        .outstanding_cnt  (cnt)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_cmd_valid = 0; m0_cmd_read = 1; m0_cmd_addr = '0;
        m0_cmd_wdata = '0; m0_cmd_wmask = '0; m0_rsp_ready = 1;
        m1_cmd_valid = 0; m1_cmd_read = 1; m1_cmd_addr = '0;
        m1_cmd_wdata = '0; m1_cmd_wmask = '0; m1_rsp_ready = 1;
        s_cmd_ready = 0; s_rsp_valid = 0; s_rsp_err = 0;
        s_rsp_rdata = '0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        #12;
        checks++;
        if (cnt !== 3'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d want 0", cnt);
        end
        checks++;
        if ({s_cmd_valid, m0_cmd_ready, m1_cmd_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_cmd: got %b want 000",
                     {s_cmd_valid, m0_cmd_ready, m1_cmd_ready});
        end
        checks++;
        if ({m0_rsp_valid, m1_rsp_valid, s_rsp_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_rsp: got %b want 000",
                     {m0_rsp_valid, m1_rsp_valid, s_rsp_ready});
        end
        cyc();
        rst_n = 1;
    endtask

    task automatic test_priority();
        cyc();
        m0_cmd_valid = 1; m0_cmd_addr = 32'h100;
        m1_cmd_valid = 1; m1_cmd_addr = 32'h200;
        s_cmd_ready = 1;
        #1;
        checks++;
        if ({m1_cmd_ready, m0_cmd_ready} !== 2'b10 || s_cmd_addr !== 32'h200) begin
            errors++;
            $display("FAIL prio_c0: rdy %b addr %h want 10 200",
                     {m1_cmd_ready, m0_cmd_ready}, s_cmd_addr);
        end
        cyc();
        m1_cmd_valid = 0;
        #1;
        checks++;
        if (m0_cmd_ready !== 1'b1 || s_cmd_addr !== 32'h100 || cnt !== 3'd1) begin
            errors++;
            $display("FAIL prio_c1: rdy %b addr %h cnt %0d want 1 100 1",
                     m0_cmd_ready, s_cmd_addr, cnt);
        end
        cyc();
        m0_cmd_valid = 0;
        s_rsp_valid = 1; s_rsp_rdata = 32'h11;
        #1;
        checks++;
        if (cnt !== 3'd2 || m1_rsp_valid !== 1'b1 || m0_rsp_valid !== 1'b0
            || m1_rsp_rdata !== 32'h11) begin
            errors++;
            $display("FAIL prio_rsp0: cnt %0d v1 %b v0 %b d %h want 2 1 0 11",
                     cnt, m1_rsp_valid, m0_rsp_valid, m1_rsp_rdata);
        end
        cyc();
        s_rsp_rdata = 32'h22;
        #1;
        checks++;
        if (m0_rsp_valid !== 1'b1 || m1_rsp_valid !== 1'b0
            || m0_rsp_rdata !== 32'h22) begin
            errors++;
            $display("FAIL prio_rsp1: v0 %b v1 %b d %h want 1 0 22",
                     m0_rsp_valid, m1_rsp_valid, m0_rsp_rdata);
        end
        cyc();
        s_rsp_valid = 0;
        s_cmd_ready = 0;
        #1;
        checks++;
        if (cnt !== 3'd0 || s_rsp_ready !== 1'b0) begin
            errors++;
            $display("FAIL prio_drain: cnt %0d srdy %b want 0 0", cnt, s_rsp_ready);
        end
    endtask

    task automatic test_lock();
        cyc();
        m0_cmd_valid = 1; m0_cmd_addr = 32'h300;
        s_cmd_ready = 0;
        #1;
        checks++;
        if (s_cmd_valid !== 1'b1 || m0_cmd_ready !== 1'b0 || s_cmd_addr !== 32'h300) begin
            errors++;
            $display("FAIL lock_c0: sv %b rdy %b addr %h want 1 0 300",
                     s_cmd_valid, m0_cmd_ready, s_cmd_addr);
        end
        cyc();
        m1_cmd_valid = 1; m1_cmd_addr = 32'h400;
        #1;
        checks++;
        if (s_cmd_addr !== 32'h300 || m1_cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL lock_c1: addr %h rdy1 %b want 300 0", s_cmd_addr, m1_cmd_ready);
        end
        cyc();
        checks++;
        if (s_cmd_addr !== 32'h300) begin
            errors++; $display("FAIL lock_c2: addr %h want 300", s_cmd_addr);
        end
        cyc();
        s_cmd_ready = 1;
        #1;
        checks++;
        if ({m0_cmd_ready, m1_cmd_ready} !== 2'b10 || s_cmd_addr !== 32'h300) begin
            errors++;
            $display("FAIL lock_c3: rdy %b addr %h want 10 300",
                     {m0_cmd_ready, m1_cmd_ready}, s_cmd_addr);
        end
        cyc();
        m0_cmd_valid = 0;
        #1;
        checks++;
        if (m1_cmd_ready !== 1'b1 || s_cmd_addr !== 32'h400) begin
            errors++;
            $display("FAIL lock_next: rdy1 %b addr %h want 1 400", m1_cmd_ready, s_cmd_addr);
        end
        cyc();
        m1_cmd_valid = 0;
        s_cmd_ready = 0;
        s_rsp_valid = 1;
        cyc();
        cyc();
        s_rsp_valid = 0;
        #1;
        checks++;
        if (cnt !== 3'd0) begin
            errors++; $display("FAIL lock_drain: cnt %0d want 0", cnt);
        end
    endtask

    task automatic test_full();
        cyc();
        m0_cmd_valid = 1; m0_cmd_addr = 32'h500;
        s_cmd_ready = 1; m0_rsp_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (m0_cmd_ready !== 1'b1 || cnt !== 3'(i)) begin
                errors++;
                $display("FAIL full_fill%0d: rdy %b cnt %0d want 1 %0d",
                         i, m0_cmd_ready, cnt, i);
            end
            cyc();
        end
        #1;
        checks++;
        if (m0_cmd_ready !== 1'b0 || s_cmd_valid !== 1'b0 || cnt !== 3'd4) begin
            errors++;
            $display("FAIL full_stall: rdy %b sv %b cnt %0d want 0 0 4",
                     m0_cmd_ready, s_cmd_valid, cnt);
        end
        s_rsp_valid = 1; m0_rsp_ready = 1;
        #1;
        checks++;
        if (s_rsp_ready !== 1'b1 || m0_cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_pop: srdy %b rdy %b want 1 0", s_rsp_ready, m0_cmd_ready);
        end
        cyc();
        s_rsp_valid = 0;
        #1;
        checks++;
        if (m0_cmd_ready !== 1'b1 || cnt !== 3'd3) begin
            errors++;
            $display("FAIL full_resume: rdy %b cnt %0d want 1 3", m0_cmd_ready, cnt);
        end
        cyc();
        m0_cmd_valid = 0;
        #1;
        checks++;
        if (cnt !== 3'd4) begin
            errors++; $display("FAIL full_refill: cnt %0d want 4", cnt);
        end
        s_rsp_valid = 1;
        repeat (4) cyc();
        s_rsp_valid = 0;
        s_cmd_ready = 0;
        #1;
        checks++;
        if (cnt !== 3'd0) begin
            errors++; $display("FAIL full_drain: cnt %0d want 0", cnt);
        end
    endtask

    task automatic test_route();
        cyc();
        s_cmd_ready = 1;
        m0_cmd_valid = 1; m0_cmd_addr = 32'h10;
        cyc();
        m0_cmd_valid = 0;
        m1_cmd_valid = 1; m1_cmd_addr = 32'h20;
        cyc();
        m1_cmd_valid = 0;
        m0_cmd_valid = 1; m0_cmd_addr = 32'h30;
        cyc();
        m0_cmd_valid = 0;
        s_cmd_ready = 0;
        s_rsp_valid = 1; s_rsp_rdata = 32'hA;
        #1;
        checks++;
        if (cnt !== 3'd3 || m0_rsp_valid !== 1'b1 || m1_rsp_valid !== 1'b0
            || m0_rsp_rdata !== 32'hA) begin
            errors++;
            $display("FAIL route_a: cnt %0d v0 %b v1 %b d %h want 3 1 0 a",
                     cnt, m0_rsp_valid, m1_rsp_valid, m0_rsp_rdata);
        end
        cyc();
        s_rsp_rdata = 32'hB; s_rsp_err = 1; m1_rsp_ready = 0;
        #1;
        checks++;
        if (s_rsp_ready !== 1'b0 || m1_rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL route_bp: srdy %b v1 %b want 0 1", s_rsp_ready, m1_rsp_valid);
        end
        cyc();
        m1_rsp_ready = 1;
        #1;
        checks++;
        if (m1_rsp_rdata !== 32'hB || m1_rsp_err !== 1'b1 || m0_rsp_valid !== 1'b0
            || s_rsp_ready !== 1'b1) begin
            errors++;
            $display("FAIL route_b: d %h err %b v0 %b srdy %b want b 1 0 1",
                     m1_rsp_rdata, m1_rsp_err, m0_rsp_valid, s_rsp_ready);
        end
        cyc();
        s_rsp_rdata = 32'hC; s_rsp_err = 0;
        #1;
        checks++;
        if (m0_rsp_valid !== 1'b1 || m0_rsp_rdata !== 32'hC || m1_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL route_c: v0 %b d %h v1 %b want 1 c 0",
                     m0_rsp_valid, m0_rsp_rdata, m1_rsp_valid);
        end
        cyc();
        #1;
        checks++;
        if (cnt !== 3'd0 || m0_rsp_valid !== 1'b0 || s_rsp_ready !== 1'b0) begin
            errors++;
            $display("FAIL route_stray: cnt %0d v0 %b srdy %b want 0 0 0",
                     cnt, m0_rsp_valid, s_rsp_ready);
        end
        s_rsp_valid = 0;
    endtask

    task automatic test_arbitration();
        logic [5:0] want;
        logic [5:0] got;
`ifdef HICORE_TCM_ARB_RR_EN
        want = 6'b010101;
`else
        want = 6'b111111;
`endif
        got = '0;
        cyc();
        m0_cmd_valid = 1; m1_cmd_valid = 1;
        s_cmd_ready = 1; s_rsp_valid = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            got[i] = m1_cmd_ready;
            cyc();
        end
        checks++;
        if (got !== want) begin
            errors++; $display("FAIL arb_seq: got %b want %b", got, want);
        end
        m0_cmd_valid = 0; m1_cmd_valid = 0;
        cyc();
        s_rsp_valid = 0;
        s_cmd_ready = 0;
        #1;
        checks++;
        if (cnt !== 3'd0) begin
            errors++; $display("FAIL arb_drain: cnt %0d want 0", cnt);
        end
    endtask

    task automatic test_reset_mid();
        cyc();
        s_cmd_ready = 1;
        m0_cmd_valid = 1;
        cyc();
        cyc();
        m0_cmd_valid = 0;
        s_cmd_ready = 0;
        #1;
        checks++;
        if (cnt !== 3'd2) begin
            errors++; $display("FAIL rstmid_pre: cnt %0d want 2", cnt);
        end
        s_rsp_valid = 1;
        rst_n = 0;
        #1;
        checks++;
        if (cnt !== 3'd0 || {m0_rsp_valid, m1_rsp_valid, s_rsp_ready} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_async: cnt %0d rsp %b want 0 000",
                     cnt, {m0_rsp_valid, m1_rsp_valid, s_rsp_ready});
        end
        cyc();
        checks++;
        if (cnt !== 3'd0 || {m0_rsp_valid, m1_rsp_valid, s_rsp_ready} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_next: cnt %0d rsp %b want 0 000",
                     cnt, {m0_rsp_valid, m1_rsp_valid, s_rsp_ready});
        end
        rst_n = 1;
        cyc();
        #1;
        checks++;
        if (cnt !== 3'd0 || s_rsp_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after: cnt %0d srdy %b want 0 0", cnt, s_rsp_ready);
        end
        s_rsp_valid = 0;
    endtask

    initial begin
        test_reset();
        test_priority();
        test_lock();
        test_full();
        test_route();
        test_arbitration();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
